// File: rtl/zjh_seg_pkg.sv
// Shared types, constants and helpers for the zjh_seg_scan display driver.
// Segment encoding is active-high {g,f,e,d,c,b,a}.
package zjh_seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [3:0] SEL_D0    = 4'b1110;

  function automatic logic [6:0] hexdec(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

  // Active-low select is valid only with exactly one low bit.
  function automatic logic sel_onehot(input logic [3:0] y_n);
    return ($countones(~y_n) == 1);
  endfunction

  function automatic logic [1:0] sel_idx(input logic [3:0] y_n);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!y_n[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/zjh_hex7seg.sv
// Combinational nibble to seven-segment decoder.
module zjh_hex7seg
  import zjh_seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = hexdec(nib);

endmodule

// File: rtl/zjh_seg_scan.sv
// Seven-segment scan driver: select sampling, double-buffered display word,
// ghosting guard FSM and sticky select-error flag.
// Optional leading-zero blanking is enabled by defining ZJH_SEG_LZB_EN.
module zjh_seg_scan
  import zjh_seg_pkg::*;
#(
  parameter int BLANK_CYC = 2,
  parameter int CNT_W     = 4
) (
  input  logic        Clock,
  input  logic        Aclr,
  input  logic [3:0]  Y_n,
  input  logic        wr_valid,
  input  logic [15:0] wr_data,
  output logic        wr_ready,
  output logic [6:0]  seg,
  output logic [3:0]  dig_n,
  output logic        sel_err
);

  logic [3:0]       y_q;
  logic             seen_reg;
  logic [15:0]      active_reg, pend_reg;
  logic             pend_full_reg, pend_full_next;
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] guard_reg, guard_next;
  logic [6:0]       seg_reg, seg_next;
  logic             err_reg, err_next;

  logic       change, frame_start, accept, sel_ok, lead_zero;
  logic [1:0] sel;
  logic [3:0] nib;
  logic [6:0] dec_seg;

  assign change      = (y_q != Y_n);
  assign frame_start = change && (Y_n == SEL_D0);
  assign accept      = wr_valid && !pend_full_reg;
  assign sel_ok      = sel_onehot(y_q);
  assign sel         = sel_idx(y_q);
  assign nib         = 4'(active_reg >> {sel, 2'b00});

  zjh_hex7seg u_dec (
    .nib (nib),
    .seg (dec_seg)
  );

`ifdef ZJH_SEG_LZB_EN
  // Blank a digit when it and every higher nibble are zero; digit 0 always shows.
  assign lead_zero = (sel != 2'd0) && ((active_reg >> {sel, 2'b00}) == 16'h0);
`else
  assign lead_zero = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    guard_next     = guard_reg;
    pend_full_next = pend_full_reg;
    if (accept) begin
      pend_full_next = 1'b1;
    end else if (frame_start) begin
      pend_full_next = 1'b0;
    end
    if (change || !sel_ok) begin
      state_next = BLANK;
      guard_next = '0;
    end else if (state_reg == BLANK) begin
      if (guard_reg == CNT_W'(BLANK_CYC - 1)) begin
        state_next = SHOW;
      end else begin
        guard_next = guard_reg + 1'b1;
      end
    end
    seg_next = (state_next == SHOW && !lead_zero) ? dec_seg : SEG_BLANK;
    // The reset value in y_q is not a real sample and must not flag an error.
    err_next = err_reg | (seen_reg && !sel_ok);
  end

  always_ff @(posedge Clock or negedge Aclr) begin
    if (!Aclr) begin
      y_q           <= 4'hF;
      seen_reg      <= 1'b0;
      active_reg    <= 16'h0;
      pend_reg      <= 16'h0;
      pend_full_reg <= 1'b0;
      state_reg     <= BLANK;
      guard_reg     <= '0;
      seg_reg       <= SEG_BLANK;
      err_reg       <= 1'b0;
    end else begin
      y_q           <= Y_n;
      seen_reg      <= 1'b1;
      if (frame_start && pend_full_reg) active_reg <= pend_reg;
      if (accept) pend_reg <= wr_data;
      pend_full_reg <= pend_full_next;
      state_reg     <= state_next;
      guard_reg     <= guard_next;
      seg_reg       <= seg_next;
      err_reg       <= err_next;
    end
  end

  assign wr_ready = !pend_full_reg;
  assign seg      = seg_reg;
  assign dig_n    = y_q;
  assign sel_err  = err_reg;

endmodule

// File: tb/tb_zjh_seg_scan.sv
// Self-checking bench for zjh_seg_scan: directed scenarios plus random scanning,
// compared against a sample-history reference model of the display rules.
module tb_zjh_seg_scan;

  localparam int BC = 2;

  logic        Clock = 1'b0;
  logic        Aclr;
  logic [3:0]  Y_n;
  logic        wr_valid;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic [6:0]  seg;
  logic [3:0]  dig_n;
  logic        sel_err;

  zjh_seg_scan #(.BLANK_CYC(BC), .CNT_W(4)) dut (
    .Clock    (Clock),
    .Aclr     (Aclr),
    .Y_n      (Y_n),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .seg      (seg),
    .dig_n    (dig_n),
    .sel_err  (sel_err)
  );

  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;

  logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: display word buffers plus the history of sampled selects.
  logic [3:0]  hist [$];
  logic [3:0]  m_last;
  logic [15:0] m_active, m_pend;
  bit          m_full, m_bad_seen, m_err;
  logic [6:0]  m_seg;

  // Bench-side source for the valid/ready port.
  bit          drv_v;
  logic [15:0] drv_d;

  function automatic bit m_onehot(input logic [3:0] y);
    int zeros = 0;
    for (int i = 0; i < 4; i++) if (y[i] == 1'b0) zeros++;
    return zeros == 1;
  endfunction

  task automatic model_reset();
    hist = {};
    for (int i = 0; i <= BC; i++) hist.push_back(4'hF);
    m_last = 4'hF; m_active = 16'h0; m_pend = 16'h0;
    m_full = 0; m_bad_seen = 0; m_err = 0; m_seg = 7'h00;
  endtask

  task automatic model_edge(input logic [3:0] y, input bit v, input logic [15:0] d, output bit acc);
    bit stable;
    int idx;
    logic [15:0] upper;
    acc = v && !m_full;
    if (y == 4'b1110 && m_last != 4'b1110 && m_full) begin
      m_active = m_pend;
      m_full   = 0;
    end
    if (acc) begin
      m_pend = d;
      m_full = 1;
    end
    m_err = m_bad_seen;
    if (!m_onehot(y)) m_bad_seen = 1;
    void'(hist.pop_front());
    hist.push_back(y);
    m_last = y;
    // A digit shows only after its select has been sampled unchanged BC+1 times.
    stable = 1;
    foreach (hist[i]) if (hist[i] != y) stable = 0;
    m_seg = 7'h00;
    if (stable && m_onehot(y)) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (y[i] == 1'b0) idx = i;
      upper = m_active >> (4 * idx);
      m_seg = seg_tbl[upper[3:0]];
`ifdef ZJH_SEG_LZB_EN
      if (idx != 0 && upper == 16'h0) m_seg = 7'h00;
`endif
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] y);
    bit acc;
    Y_n = y; wr_valid = drv_v; wr_data = drv_d;
    @(posedge Clock);
    model_edge(y, drv_v, drv_d, acc);
    #1;
    if (acc) begin
      $display("load accepted: word=%h at t=%0t", drv_d, $time);
      drv_v = 0;
    end
    chk("seg", 16'(seg), 16'(m_seg));
    chk("dig_n", 16'(dig_n), 16'(y));
    chk("wr_ready", 16'(wr_ready), 16'(!m_full));
    chk("sel_err", 16'(sel_err), 16'(m_err));
  endtask

  task automatic scan_frame(input int dwell);
    logic [3:0] sels [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int k = 0; k < 4; k++) repeat (dwell) step(sels[k]);
  endtask

  task automatic load(input logic [15:0] w);
    drv_v = 1; drv_d = w;
  endtask

  initial begin
    logic [3:0] sels [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    int d;
    drv_v = 0; drv_d = 16'h0;
    Aclr = 1'b0; Y_n = 4'b1110; wr_valid = 1'b0; wr_data = 16'h0;
    model_reset();
    repeat (3) @(negedge Clock);
    chk("rst_seg", 16'(seg), 16'h0);
    chk("rst_dig_n", 16'(dig_n), 16'hF);
    chk("rst_wr_ready", 16'(wr_ready), 16'h1);
    chk("rst_sel_err", 16'(sel_err), 16'h0);
    Aclr = 1'b1;

    // Stable digit 0 after reset: blank for the guard, then the zero pattern.
    repeat (5) step(4'b1110);

    // Mid-frame load: old word finishes the frame, new word from next digit 0.
    step(4'b1101);
    load(16'h12A8);
    repeat (4) step(4'b1101);
    repeat (4) step(4'b1011);
    repeat (4) step(4'b0111);
    scan_frame(4);

    // Back-pressure: second word waits for the digit-0 promotion.
    load(16'hBEEF);
    step(4'b0111);
    load(16'h4C5D);
    repeat (3) step(4'b0111);
    scan_frame(4);
    scan_frame(4);

    // Leading-zero candidate word.
    load(16'h0070);
    scan_frame(4);
    scan_frame(4);

    // Non-one-hot select glitch; error stays sticky.
    step(4'b1100);
    scan_frame(4);

    // Asynchronous reset while showing a digit.
    step(4'b1110);
    Aclr = 1'b0;
    #1;
    chk("arst_seg", 16'(seg), 16'h0);
    chk("arst_dig_n", 16'(dig_n), 16'hF);
    chk("arst_wr_ready", 16'(wr_ready), 16'h1);
    chk("arst_sel_err", 16'(sel_err), 16'h0);
    @(negedge Clock);
    Aclr = 1'b1;
    model_reset();
    drv_v = 0;
    load(16'h3069);
    scan_frame(4);
    scan_frame(4);

    // Random scanning with varying dwell, sporadic glitches and loads.
    for (int n = 0; n < 200; n++) begin
      if (!drv_v && ($urandom_range(3) == 0)) load(16'($urandom));
      d = $urandom_range(5, 1);
      if ($urandom_range(19) == 0) begin
        step(4'($urandom));
      end else begin
        repeat (d) step(sels[n % 4]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
